// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds widths, iteration count, op and FSM encodings, and small helpers.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Conditional two's-complement negation of a word.
    function automatic logic [XLEN-1:0] neg_if(
        input logic [XLEN-1:0] v,
        input logic            n
    );
        return n ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation of a double word.
    function automatic logic [2*XLEN-1:0] neg_if2(
        input logic [2*XLEN-1:0] v,
        input logic              n
    );
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One combinational iteration of the multiply/divide datapath.
// Ports: div_mode selects restoring divide vs shift-add multiply;
//        acc is the 64-bit working register, operand the multiplicand
//        (multiply) or divisor (divide); acc_next is the updated register.
module muldiv_core (
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    import muldiv_pkg::*;

    logic [32:0] mul_sum;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;

    always_comb begin
        // Multiply: acc = {partial high, remaining multiplier bits}.
        // Add the multiplicand on the LSB, then shift everything right.
        mul_sum = {1'b0, acc[63:32]}
                + (acc[0] ? {1'b0, operand} : 33'd0);

        // Divide: acc = {partial remainder, dividend bits / quotient}.
        // Shift the next dividend bit in and trial-subtract the divisor.
        div_diff = {1'b0, acc[63:32], acc[31]} - {2'b00, operand};
        div_ge   = ~div_diff[33];
        div_rem  = div_ge ? div_diff[31:0] : {acc[62:32], acc[31]};

        if (div_mode) begin
            acc_next = {div_rem, acc[30:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file writeback.
// Ports: clk, reset (async, active high); start/funct3/rs1_data/rs2_data/
//        rd_in request; busy, done, wb_enable, wb_reg, wb_data result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wb_enable,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data
);

    import muldiv_pkg::*;

    state_t      state;
    op_t         op;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic        neg_res;
    logic        neg_rem;

    op_t         req_op;
    logic        req_sa;
    logic        req_sb;
    logic [31:0] req_amag;
    logic [31:0] req_bmag;
    logic        req_div;
    logic        req_zero;
    logic        req_ovf;
    logic        req_fast;
    logic [31:0] fast_data;

    logic [63:0] acc_next;
    logic        last;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] result;

    // Request decode: which operands are treated as signed, and the
    // divide corner cases that skip the iterative path.
    always_comb begin
        req_op = op_t'(funct3);
        req_sa = 1'b0;
        req_sb = 1'b0;
        unique case (req_op)
            OP_MULH: begin
                req_sa = rs1_data[31];
                req_sb = rs2_data[31];
            end
            OP_MULHSU: req_sa = rs1_data[31];
            OP_DIV, OP_REM: begin
                req_sa = rs1_data[31];
                req_sb = rs2_data[31];
            end
            default: ;
        endcase

        req_amag = neg_if(rs1_data, req_sa);
        req_bmag = neg_if(rs2_data, req_sb);

        req_div  = funct3[2];
        req_zero = req_div && (rs2_data == 32'd0);
        req_ovf  = (req_op == OP_DIV || req_op == OP_REM)
                && (rs1_data == 32'h8000_0000)
                && (rs2_data == 32'hFFFF_FFFF);
        req_fast = req_zero || req_ovf;

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (req_zero) begin
            fast_data = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            fast_data = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    muldiv_core u_core (
        .div_mode (state == DIV),
        .acc      (acc),
        .operand  (mcand),
        .acc_next (acc_next)
    );

    // Sign fix-up on the value produced by the final iteration.
    always_comb begin
        last = (count == 6'(ITER - 1));
        prod = neg_if2(acc_next, neg_res);
        quot = neg_if(acc_next[31:0], neg_res);
        rem  = neg_if(acc_next[63:32], neg_rem);
        unique case (op)
            OP_MUL:                       result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[63:32];
            OP_DIV, OP_DIVU:              result = quot;
            OP_REM, OP_REMU:              result = rem;
            default:                      result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= OP_MUL;
            count   <= 6'd0;
            acc     <= 64'd0;
            mcand   <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_reg  <= 5'd0;
            wb_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op      <= req_op;
                        wb_reg  <= rd_in;
                        count   <= 6'd0;
                        neg_res <= req_sa ^ req_sb;
                        neg_rem <= req_sa;
                        busy    <= 1'b1;
                        // Multiply iterates over the multiplier (rs2),
                        // divide shifts the dividend (rs1) through acc.
                        if (req_div) begin
                            acc   <= {32'd0, req_amag};
                            mcand <= req_bmag;
                        end else begin
                            acc   <= {32'd0, req_bmag};
                            mcand <= req_amag;
                        end
                        if (req_fast) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wb_data <= fast_data;
                        end else if (req_div) begin
                            state <= DIV;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc   <= acc_next;
                    count <= count + 6'd1;
                    if (last) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wb_data <= result;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // x0 is hard-wired to zero, so never write it back.
    assign wb_enable = done && (wb_reg != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, corner
// cases, start-while-busy, mid-op reset and randomized ops vs a model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int          n_checks;
    int          n_errors;
    logic [31:0] prev_data;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .wb_enable (wb_enable),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        a64 = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
        b64 = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = a64 * b64;
        case (f3)
            3'b000:  return p[31:0];
            3'b001,
            3'b010,
            3'b011:  return p[63:32];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF
                          : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op with start in cycle 0; optionally pulse a spurious
    // start (random operands) in cycle glitch_at while busy.
    task automatic run_op(
        input string       tag,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  rd,
        input int          glitch_at
    );
        logic [31:0] exp_d;
        int          exp_lat;
        int          cyc;
        exp_d   = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk);
        start    = 1'b1;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        check({tag, " busy"}, busy, 1);
        if (exp_lat > 1) begin
            check({tag, " hold"}, wb_data, prev_data);
        end
        while (!done && cyc < 40) begin
            if (cyc == glitch_at) begin
                start    = 1'b1;
                funct3   = 3'($urandom);
                rs1_data = $urandom;
                rs2_data = $urandom;
                rd_in    = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " data"}, wb_data, exp_d);
        check({tag, " wb_reg"}, wb_reg, rd);
        check({tag, " wb_en"}, wb_enable, rd != 0);
        prev_data = exp_d;
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_data = 32'd0;
        reset     = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        rd_in     = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst wb_en", wb_enable, 0);
        check("rst wb_reg", wb_reg, 0);
        check("rst wb_data", wb_data, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul", 3'b000, 32'd150, 32'd999, 5'd5, -1);
        check("mul value", prev_data, 32'h0002_495A);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'd2, 5'd6, -1);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd2, 5'd7, -1);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, -1);
        run_op("div", 3'b100, 32'd999, 32'd10, 5'd9, -1);
        run_op("rem", 3'b110, 32'd999, 32'd10, 5'd10, -1);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, -1);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, -1);
        run_op("divu_z", 3'b101, 32'd109, 32'd0, 5'd13, -1);
        run_op("remu_z", 3'b111, 32'd109, 32'd0, 5'd14, -1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, -1);
        run_op("div_ovf2", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1);
        run_op("mul_x0", 3'b000, 32'd3, 32'd4, 5'd0, -1);
        run_op("busy_start", 3'b100, 32'd100_000, 32'd7, 5'd17, 5);

        // Reset mid-cycle during cycle 10 of a DIV.
        @(negedge clk);
        start    = 1'b1;
        funct3   = 3'b100;
        rs1_data = 32'd12345;
        rs2_data = 32'd7;
        rd_in    = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst wb_en", wb_enable, 0);
        check("arst wb_reg", wb_reg, 0);
        check("arst wb_data", wb_data, 0);
        prev_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 0) check("arst no_done", done, 0);
        end
        run_op("div_after_rst", 3'b100, 32'd999, 32'd10, 5'd9, -1);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom), pick_operand(), pick_operand(),
                   5'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-005 SHALL have port funct3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data, input, 32, operand A, taken from register file read port A.
REQ-007 SHALL have port rs2_data, input, 32, operand B, taken from register file read port B.
REQ-008 SHALL have port rd_in, input, 5, destination register index.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse while in DONE.
REQ-011 SHALL have port wb_enable, output, 1, equal to done AND (wb_reg != 0); drives the register file write enable.
REQ-012 SHALL have port wb_reg, output, 5, latched rd_in; drives the register file write index.
REQ-013 SHALL have port wb_data, output, 32, result register; drives the register file write data.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE, where DONE always returns to IDLE on the next edge.
REQ-015 SHALL, on an edge in IDLE with start=1, latch funct3, both operands and rd_in, and go to MUL for funct3[2]=0 or to DIV for funct3[2]=1.
REQ-016 SHALL ignore start in MUL, DIV and DONE; no queuing, and latched operands are unaffected.
REQ-017 SHALL perform one shift-add or restoring-subtract iteration per cycle, with a 6-bit counter; after exactly 32 iterations it enters DONE.
REQ-018 SHALL, taking the start cycle as cycle 0, assert done in cycle 33 for iterative ops.
REQ-019 SHALL compute multiplies on operand magnitudes with a 64-bit unsigned product, negated when the effective signs differ.
REQ-020 SHALL treat both operands as signed for MULH, rs1 signed and rs2 unsigned for MULHSU, and both unsigned for MULHU and MUL.
REQ-021 SHALL return product[31:0] for MUL and product[63:32] for the high variants.
REQ-022 SHALL divide magnitudes for signed division.
REQ-023 SHALL give the quotient the sign of (rs1 XOR rs2) and the remainder the sign of rs1, so the quotient truncates toward zero.
REQ-024 SHALL, for divide by zero, go directly IDLE->DONE with done in cycle 1, quotient 0xFFFFFFFF and remainder = rs1.
REQ-025 SHALL, for signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF), take the fast path with quotient 0x80000000 and remainder 0.
REQ-026 SHALL register wb_data on the edge entering DONE and hold it unchanged until the next accepted start completes.
REQ-027 SHALL hold wb_reg from accept until the next accept.
REQ-028 SHALL allow a start asserted in the cycle after DONE (back in IDLE) to be accepted, giving a minimum issue interval of 34 cycles.

Reset
REQ-029 SHALL, on reset, immediately and asynchronously force state=IDLE, counter=0, busy=0, done=0, wb_enable=0, wb_reg=0, wb_data=0 and all internal operand/accumulator registers to 0.
REQ-030 SHALL, when reset asserts mid-operation, abort the operation with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-031 SHALL place in shared package muldiv_pkg: XLEN, the op_t enum of the eight funct3 encodings, state_t (IDLE, MUL, DIV, DONE), and ITER=32.
REQ-032 SHALL keep FSM, counter and sign fix-up in muldiv_unit.
REQ-033 SHALL place the iteration datapath in the single sub-module muldiv_core (one shift-add/subtract step per call cycle, combinational).

Verification
REQ-034 SHALL cover: MUL 150*999, rd=5 -> done in cycle 33, wb_data=0x0002495A, wb_enable=1, wb_reg=5.
REQ-035 SHALL cover: MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001; MULHSU same operands -> 0xFFFFFFFF.
REQ-036 SHALL cover: DIV 999/10 -> 99; REM 999/10 -> 9; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-037 SHALL cover: DIVU 109/0 -> 0xFFFFFFFF and REMU 109/0 -> 109, each with done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with done in cycle 1.
REQ-038 SHALL cover: MUL rd=0 -> done=1 with wb_enable=0; start pulsed in cycle 5 of a busy op -> ignored, and the original result completes unchanged.
REQ-039 SHALL cover: reset asserted mid-cycle at cycle 10 of a DIV -> busy and wb_data read 0 before the next edge, with no done pulse; a new DIV 999/10 after release -> 99 in cycle 33.
